parity_frame_rx: RTL
====================

// Module: parity_frame_rx
// PURPOSE
// Serial receiver that checks the parity bit appended by the parity generator.
// Deserialises a frame of start bit, DATA_W data bits (LSB first), parity bit and stop bit.
// Recomputes parity over the received data and flags parity and framing errors.
// Sits between the serial link and the word-level consumer. The bit strobe comes from the link's bit-timing logic.
// PARAMETERS
// DATA_W      16   data bits per frame, 2..32
// ODD_PARITY  0    0 = even parity expected, 1 = odd parity expected
// PORTS
// clk         in   1        system clock, all logic on rising edge
// rst_n       in   1        synchronous active-low reset
// bit_stb     in   1        one-cycle strobe: sample ser_in this cycle
// ser_in      in   1        serial line, idle high
// rx_data     out  DATA_W   last received word, held until next frame completes
// rx_valid    out  1        one-cycle pulse: frame complete, rx_data/flags updated
// parity_err  out  1        parity mismatch on last frame, held
// frame_err   out  1        stop bit was 0 on last frame, held
// busy        out  1        high while a frame is in progress (state != IDLE)
// err_count   out  8        saturating error counter (only with PRX_ERR_COUNT_EN)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, shift reg=0, bit counter=0.
//   Outputs after reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
// - Reset mid-frame aborts the frame silently: no rx_valid, held outputs cleared.
// - All sampling is qualified by bit_stb. Cycles without bit_stb never change state.
// - FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
//   IDLE: on bit_stb && ser_in==0 (start bit) -> DATA; clear the bit counter and the running parity.
//   DATA: on each bit_stb, shift ser_in into the MSB of the shift reg (LSB-first frame), XOR it into the running parity, and increment the counter.
//     After DATA_W bits -> PARITY.
//   PARITY: on bit_stb, store perr = running_parity ^ ser_in ^ ODD_PARITY.
//     perr=1 means mismatch. Then -> STOP.
//   STOP: on bit_stb, in the same edge: update rx_data, set parity_err=perr, set frame_err=~ser_in, and assert rx_valid for the next cycle only.
//     If ser_in==1 -> IDLE; if ser_in==0 -> WAIT_IDLE.
//   WAIT_IDLE: stay until bit_stb && ser_in==1, then -> IDLE.
//     This prevents a held-low line (break) from being taken as a new start bit.
// - Latency: rx_valid is high in the cycle after the clock edge that samples the stop bit.
// - Frames with errors still deliver rx_data and pulse rx_valid; the consumer decides whether to discard.
// - No false-start filtering. A glitch that is low at the bit_stb sample starts a frame.
// - Back-to-back frames: a start bit strobed in the cycle right after STOP (now IDLE) is accepted.
// - bit_stb held high for consecutive cycles is legal: one bit is sampled per cycle.
// - busy=1 in DATA, PARITY, STOP and WAIT_IDLE.
// CONFIGURATION
// - PRX_ERR_COUNT_EN defined:
//   err_count increments by 1 on each rx_valid with parity_err|frame_err.
//   It saturates at 8'hFF and clears only on reset.
// - PRX_ERR_COUNT_EN undefined:
//   the counter logic is not built and err_count is tied to 8'h00. The port is still present.
// TESTING
// Default parameters. One bit_stb every 4 clocks unless noted. Notation: start, 16 data bits (LSB first), parity, stop.
// 1. Frame with data 16'h0001, parity 1, stop 1:
//    -> rx_valid one pulse, rx_data=16'h0001, parity_err=0, frame_err=0.
// 2. Frame with data 16'h000B, parity 0 (wrong; correct value is 1), stop 1:
//    -> rx_data=16'h000B, parity_err=1, frame_err=0.
// 3. Frame with data 16'h000A, parity 0, stop 0, then ser_in held 0 for 5 strobes:
//    -> frame_err=1, busy stays 1 and no new frame starts.
//    -> ser_in=1 on a strobe -> busy=0.
// 4. Reset mid-frame: assert rst_n=0 after 8 data bits of 16'h00FF, then send a clean frame with data 16'h000F:
//    -> no rx_valid for the aborted frame; rx_data=16'h000F, no errors.
// 5. Two frames back-to-back with bit_stb high every cycle: data 16'h0005 then 16'h0009, both with correct parity:
//    -> two rx_valid pulses 19 cycles apart, both with parity_err=0.
// 6. With PRX_ERR_COUNT_EN defined: run 300 frames with bad parity
//    -> err_count=8'hFF. Without the macro, err_count=8'h00 throughout.

Source files
------------

// File: rtl/parity_frame_rx.sv
// Serial parity-checking frame receiver: start, DATA_W data bits (LSB first), parity, stop.
// Optional saturating error counter enabled by defining PRX_ERR_COUNT_EN.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 16,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_stb,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;
  logic               run_par;
  logic               perr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_stb) begin
      case (state)
        IDLE:      if (!ser_in) state_nxt = DATA;
        DATA:      if (cnt == CNT_W'(DATA_W - 1)) state_nxt = PARITY;
        PARITY:    state_nxt = STOP;
        // A low stop bit means the line may be in break; wait for it to rise.
        STOP:      state_nxt = ser_in ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (ser_in) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      run_par    <= 1'b0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bit_stb) begin
        case (state)
          IDLE: begin
            if (!ser_in) begin
              cnt     <= '0;
              run_par <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {ser_in, shreg[DATA_W-1:1]};
            run_par <= run_par ^ ser_in;
            cnt     <= cnt + 1'b1;
          end
          PARITY: perr <= run_par ^ ser_in ^ ODD_PARITY;
          STOP: begin
            rx_data    <= shreg;
            parity_err <= perr;
            frame_err  <= ~ser_in;
            rx_valid   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef PRX_ERR_COUNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (rx_valid && (parity_err || frame_err) && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  assign err_count = err_cnt;
`else
  assign err_count = '0;
`endif

endmodule
